// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - 720p raster constants and shared counter widths
//
// Purpose: 1280x720 @ 60 Hz timing constants, derived line/frame totals and
//          the counter widths shared by the timing generator and every
//          sprite/overlay block that consumes hcount/vcount.
// Ports:   none (package).
package video_timing_pkg;

  localparam int ACTIVE_H_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int ACTIVE_V_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;
  localparam int FPS_720P      = 60;

  localparam int TOTAL_H_720P = ACTIVE_H_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
  localparam int TOTAL_V_720P = ACTIVE_V_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;
  localparam int FC_W    = 6;

  localparam int MAX_SYNC_DELAY = 8;

  typedef logic [H_CNT_W-1:0] hcount_t;
  typedef logic [V_CNT_W-1:0] vcount_t;
  typedef logic [FC_W-1:0]    fcount_t;

  // One bit wider than the counters so boundaries equal to 2^W still compare
  // correctly instead of truncating to zero.
  typedef logic [H_CNT_W:0] hcmp_t;
  typedef logic [V_CNT_W:0] vcmp_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic ad;
  } sync_bus_t;

  localparam int SYNC_W = $bits(sync_bus_t);

endpackage

// File: rtl/sig_delay.sv
// rtl/sig_delay.sv - generic DEPTH x WIDTH shift register with async clear
//
// Purpose: delays a WIDTH-bit bus by exactly DEPTH clock edges. DEPTH = 0
//          is a combinational pass-through.
// Ports:
//   i_clk    - clock
//   i_rst_n  - asynchronous active-low clear of every stage
//   i_data   - bus to delay
//   o_data   - i_data delayed by DEPTH edges
module sig_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = i_clk ^ i_rst_n;
      assign o_data   = i_data;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
          end
        end else begin
          r_stage[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_sig_gen.sv
// rtl/video_sig_gen.sv - raster timing generator with sync, draw and frame strobes
//
// Purpose: scans hcount/vcount over the full raster and produces HSYNC,
//          VSYNC, active-draw and new-frame flags registered in the same
//          cycle as the counters, a frame counter, and copies of the sync
//          and active flags delayed to match the pixel pipeline.
// Ports:
//   clk_in     - pixel clock
//   rst_in     - asynchronous active-low reset
//   hcount_out - horizontal position
//   vcount_out - vertical position
//   hs_out     - HSYNC, active high
//   vs_out     - VSYNC, active high, whole lines
//   ad_out     - position is inside the visible area
//   nf_out     - one-cycle strobe at the first blanking pixel after the last
//                visible line
//   fc_out     - frame count 0..FPS-1, advances with nf_out
//   hs_d_out, vs_d_out, ad_d_out - hs/vs/ad delayed by SYNC_DELAY cycles
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int ACTIVE_H   = ACTIVE_H_720P,
  parameter int H_FP       = H_FP_720P,
  parameter int H_SYNC     = H_SYNC_720P,
  parameter int H_BP       = H_BP_720P,
  parameter int ACTIVE_V   = ACTIVE_V_720P,
  parameter int V_FP       = V_FP_720P,
  parameter int V_SYNC     = V_SYNC_720P,
  parameter int V_BP       = V_BP_720P,
  parameter int FPS        = FPS_720P,
  parameter int SYNC_DELAY = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  output logic [H_CNT_W-1:0] hcount_out,
  output logic [V_CNT_W-1:0] vcount_out,
  output logic               hs_out,
  output logic               vs_out,
  output logic               ad_out,
  output logic               nf_out,
  output logic [FC_W-1:0]    fc_out,
  output logic               hs_d_out,
  output logic               vs_d_out,
  output logic               ad_d_out
);

  localparam int TOTAL_H = ACTIVE_H + H_FP + H_SYNC + H_BP;
  localparam int TOTAL_V = ACTIVE_V + V_FP + V_SYNC + V_BP;

  generate
    if (TOTAL_H > (1 << H_CNT_W) || TOTAL_H < 1) begin : g_chk_total_h
      $fatal(1, "video_sig_gen: TOTAL_H out of range");
    end
    if (TOTAL_V > (1 << V_CNT_W) || TOTAL_V < 1) begin : g_chk_total_v
      $fatal(1, "video_sig_gen: TOTAL_V out of range");
    end
    if (FPS > (1 << FC_W) || FPS < 1) begin : g_chk_fps
      $fatal(1, "video_sig_gen: FPS out of range");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > MAX_SYNC_DELAY) begin : g_chk_delay
      $fatal(1, "video_sig_gen: SYNC_DELAY out of range");
    end
  endgenerate

  localparam hcount_t H_LAST  = hcount_t'(TOTAL_H - 1);
  localparam vcount_t V_LAST  = vcount_t'(TOTAL_V - 1);
  localparam fcount_t FC_LAST = fcount_t'(FPS - 1);

  localparam hcmp_t H_ACT_END  = hcmp_t'(ACTIVE_H);
  localparam hcmp_t H_SYNC_BEG = hcmp_t'(ACTIVE_H + H_FP);
  localparam hcmp_t H_SYNC_END = hcmp_t'(ACTIVE_H + H_FP + H_SYNC);
  localparam vcmp_t V_ACT_END  = vcmp_t'(ACTIVE_V);
  localparam vcmp_t V_SYNC_BEG = vcmp_t'(ACTIVE_V + V_FP);
  localparam vcmp_t V_SYNC_END = vcmp_t'(ACTIVE_V + V_FP + V_SYNC);

  hcount_t   r_hcount;
  vcount_t   r_vcount;
  fcount_t   r_fc;
  logic      r_hs;
  logic      r_vs;
  logic      r_ad;
  logic      r_nf;

  hcount_t   w_hcount_next;
  vcount_t   w_vcount_next;
  fcount_t   w_fc_next;
  hcmp_t     w_h_cmp;
  vcmp_t     w_v_cmp;
  logic      w_h_wrap;
  logic      w_hs_next;
  logic      w_vs_next;
  logic      w_ad_next;
  logic      w_nf_next;
  sync_bus_t w_sync_now;
  sync_bus_t w_sync_dly;

  // Flags are decoded from the next counter pair so that, once registered,
  // they describe exactly the position shown on hcount_out/vcount_out.
  always_comb begin
    w_h_wrap      = (r_hcount == H_LAST);
    w_hcount_next = w_h_wrap ? '0 : r_hcount + 1'b1;
    w_vcount_next = r_vcount;
    if (w_h_wrap) begin
      w_vcount_next = (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
    end

    w_h_cmp   = {1'b0, w_hcount_next};
    w_v_cmp   = {1'b0, w_vcount_next};
    w_ad_next = (w_h_cmp < H_ACT_END) && (w_v_cmp < V_ACT_END);
    w_hs_next = (w_h_cmp >= H_SYNC_BEG) && (w_h_cmp < H_SYNC_END);
    w_vs_next = (w_v_cmp >= V_SYNC_BEG) && (w_v_cmp < V_SYNC_END);
    w_nf_next = (w_h_cmp == H_ACT_END) && (w_v_cmp == V_ACT_END);

    w_fc_next = (r_fc == FC_LAST) ? '0 : r_fc + 1'b1;
  end

  // Reset parks the counters on the last raster position so the first edge
  // after release lands on (0,0).
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_hcount <= H_LAST;
      r_vcount <= V_LAST;
      r_hs     <= 1'b0;
      r_vs     <= 1'b0;
      r_ad     <= 1'b0;
      r_nf     <= 1'b0;
      r_fc     <= '0;
    end else begin
      r_hcount <= w_hcount_next;
      r_vcount <= w_vcount_next;
      r_hs     <= w_hs_next;
      r_vs     <= w_vs_next;
      r_ad     <= w_ad_next;
      r_nf     <= w_nf_next;
      if (w_nf_next) begin
        r_fc <= w_fc_next;
      end
    end
  end

  assign w_sync_now = '{hs: r_hs, vs: r_vs, ad: r_ad};

  sig_delay #(
    .DEPTH (SYNC_DELAY),
    .WIDTH (SYNC_W)
  ) u_sync_delay (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_data  (w_sync_now),
    .o_data  (w_sync_dly)
  );

  assign hcount_out = r_hcount;
  assign vcount_out = r_vcount;
  assign hs_out     = r_hs;
  assign vs_out     = r_vs;
  assign ad_out     = r_ad;
  assign nf_out     = r_nf;
  assign fc_out     = r_fc;
  assign hs_d_out   = w_sync_dly.hs;
  assign vs_d_out   = w_sync_dly.vs;
  assign ad_d_out   = w_sync_dly.ad;

endmodule
